hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Counterpart to the forwarding unit: it handles the dependencies forwarding cannot resolve.
- Owns all pipeline-register enable and flush controls for the 5-stage MIPS pipeline.
- Stalls on load-use and branch-operand hazards, freezes on memory waits, squashes wrong-path fetches, and latches halt.
- Sits beside the forwarding unit in datapath; consumes the same per-stage dest/rfWEN information.

Parameters:
- BR_LOAD_STALL, 2, stall cycles for a decode-stage branch whose operand is a load in EX.
- BR_ALU_STALL, 1, stall cycles for a decode-stage branch whose operand is an ALU result in EX.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- dec_rs, dec_rt  in  5 (regbits_t)  source regs of instr in decode
- dec_uses_rs, dec_uses_rt  in  1  source actually read
- dec_isbr  in  1  decode instr is a register-compare branch
- dec_redirect  in  1  decode resolved taken branch/jump
- ex_dest  in  5  EX destination
- ex_rfWEN, ex_memREN  in  1  EX writes RF / is a load
- mem_dREN, mem_dWEN  in  1  MEM data request
- dhit, ihit  in  1  cache ready
- wb_halt  in  1  halt reached WB
- pcEN, if_id_EN, id_ex_EN, ex_mem_EN, mem_wb_EN  out  1  register enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  insert bubble
- halt  out  1  sticky halt
- stall_cycles, flush_count  out  32  perf counters (see Optional Feature)

Behaviour:
- Registered state: hzState (RUN, STALL, HALTED), stall_cnt (2b), squash_pending (1b). Outputs are Mealy: f(state, inputs).
- Reset (RST high at CLK edge): state=RUN, stall_cnt=0, squash_pending=0.
- Outputs while RST is asserted: all EN=1, all flush=0, halt=0.
- RST mid-stall or in HALTED returns to RUN on the next edge.
- Per-cycle priority: HALTED > dmem wait > decode stall > redirect > imem wait > run.
- HALTED: all EN=0, flushes=0, halt=1. Entered on the edge when wb_halt=1. Leaves only via RST.
- Dmem wait: (mem_dREN|mem_dWEN)&!dhit.
  - pcEN=if_id_EN=id_ex_EN=ex_mem_EN=0.
  - mem_wb_EN=1, mem_wb_flush=1.
  - stall_cnt frozen; squash_pending may still be set.
- Load-use hazard: ex_memREN & ex_rfWEN & ex_dest!=0 & ((dec_uses_rs & dec_rs==ex_dest) | (dec_uses_rt & dec_rt==ex_dest)).
- Branch dependency: dec_isbr & ex_rfWEN & ex_dest!=0 & same register match.
- On the detecting cycle (state RUN):
  - pcEN=if_id_EN=0, id_ex_flush=1.
  - stall_cnt loads (load: BR_LOAD_STALL or 1 for non-branch load-use; ALU: BR_ALU_STALL) minus 1.
  - state goes to STALL if that result is nonzero.
- STALL: same outputs; stall_cnt decrements; detection suppressed; returns to RUN when stall_cnt reaches 0 after the decrement.
- Redirect (no higher-priority condition):
  - ihit=1: if_id_flush=1.
  - ihit=0: squash_pending<=1 and the IF/ID register holds.
- Imem wait (!ihit): pcEN=0, if_id_flush=1; downstream advances.
- When ihit=1 and squash_pending=1: if_id_flush=1 and squash_pending clears, even if dec_redirect=0.
- Simultaneous redirect + load-use stall: stall wins; redirect is re-evaluated when the branch leaves decode stall.
- ex_dest==0 never causes a hazard.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments each cycle with pcEN=0 and state!=HALTED.
  - flush_count increments each cycle any flush=1.
  - Both clear on RST and saturate at 32'hFFFFFFFF.
- Undefined: both ports driven 32'h0 and no counter flops are synthesized.

Decomposition:
- hazard_types_pkg: hzState enum, stall-count width constant.
- regbits_t and word_t come from cpu_types_pkg.
- Sub-module hazard_detect: combinational register-match/hazard classification (load-use, branch-ALU, branch-load). The FSM and counters stay in hazard_unit.

Test Plan:
- lw $2 in EX (ex_memREN=1, ex_dest=2), decode add reads rs=2 -> 1 cycle with pcEN=0, if_id_EN=0, id_ex_flush=1; next cycle all EN=1.
- beq rs=3 decode, EX lw dest=3 -> pcEN=0 exactly 2 cycles with stall_cnt 1->0; beq with EX addu dest=3 -> 1 cycle.
- mem_dREN=1, dhit=0 for 4 cycles during a load-use stall -> front EN=0, mem_wb_flush=1 for 4 cycles; stall_cnt unchanged; resumes on dhit.
- dec_redirect=1 with ihit=0 for 3 cycles -> squash_pending=1; on ihit=1 if_id_flush=1 once, then squash_pending=0.
- wb_halt=1 -> halt=1 and all EN=0 from next cycle for 10+ cycles; RST=1 -> halt=0, state RUN.
- HAZARD_PERF_EN: 3 stall cycles + 2 flushes -> stall_cycles=3, flush_count=2; without the macro both read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU datapath types: register index and data word.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;
   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;
endpackage
`default_nettype wire

// File: rtl/hazard_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_types_pkg
//  Description : Hazard-unit control state encoding and stall counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_types_pkg;
   localparam int STALL_CNT_W = 2;

   typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_STALL  = 2'd1,
      HZ_HALTED = 2'd2
   } hzState_t;
endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational classification of the decode-stage instruction
//                against the EX-stage producer.
//  Ports       : i_dec_rs/i_dec_rt, i_dec_uses_rs/i_dec_uses_rt, i_dec_isbr
//                i_ex_dest, i_ex_rfWEN, i_ex_memREN
//                o_load_use : non-branch consumer of a load in EX
//                o_br_load  : register-compare branch consuming a load in EX
//                o_br_alu   : register-compare branch consuming an ALU result
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
   import cpu_types_pkg::*;
(
   input  regbits_t i_dec_rs,
   input  regbits_t i_dec_rt,
   input  logic     i_dec_uses_rs,
   input  logic     i_dec_uses_rt,
   input  logic     i_dec_isbr,
   input  regbits_t i_ex_dest,
   input  logic     i_ex_rfWEN,
   input  logic     i_ex_memREN,
   output logic     o_load_use,
   output logic     o_br_load,
   output logic     o_br_alu
);
   logic w_match;

   // $zero is never a real producer, so it can never create a dependency.
   assign w_match = i_ex_rfWEN && (i_ex_dest != '0) &&
                    ((i_dec_uses_rs && (i_dec_rs == i_ex_dest)) ||
                     (i_dec_uses_rt && (i_dec_rt == i_ex_dest)));

   assign o_br_load  = i_dec_isbr  &&  i_ex_memREN && w_match;
   assign o_br_alu   = i_dec_isbr  && !i_ex_memREN && w_match;
   assign o_load_use = !i_dec_isbr &&  i_ex_memREN && w_match;
endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline enable/flush control for the 5-stage MIPS pipeline:
//                load-use and branch-operand stalls, data-memory freeze,
//                wrong-path fetch squash and sticky halt.
//  Ports       : CLK, RST (sync, active high)
//                dec_* : decode-stage sources / branch / redirect
//                ex_*  : EX-stage destination, RF write, load
//                mem_dREN/mem_dWEN, dhit, ihit, wb_halt
//                pcEN, if_id_EN, id_ex_EN, ex_mem_EN, mem_wb_EN
//                if_id_flush, id_ex_flush, mem_wb_flush, halt
//                stall_cycles, flush_count : performance counters
//  Config      : HAZARD_PERF_EN enables the performance counters; otherwise
//                both counter ports are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
   import cpu_types_pkg::*;
   import hazard_types_pkg::*;
#(
   parameter int BR_LOAD_STALL = 2,
   parameter int BR_ALU_STALL  = 1
)(
   input  logic     CLK,
   input  logic     RST,
   input  regbits_t dec_rs,
   input  regbits_t dec_rt,
   input  logic     dec_uses_rs,
   input  logic     dec_uses_rt,
   input  logic     dec_isbr,
   input  logic     dec_redirect,
   input  regbits_t ex_dest,
   input  logic     ex_rfWEN,
   input  logic     ex_memREN,
   input  logic     mem_dREN,
   input  logic     mem_dWEN,
   input  logic     dhit,
   input  logic     ihit,
   input  logic     wb_halt,
   output logic     pcEN,
   output logic     if_id_EN,
   output logic     id_ex_EN,
   output logic     ex_mem_EN,
   output logic     mem_wb_EN,
   output logic     if_id_flush,
   output logic     id_ex_flush,
   output logic     mem_wb_flush,
   output logic     halt,
   output word_t    stall_cycles,
   output word_t    flush_count
);
   // The detecting cycle is itself the first stall cycle, so the counter
   // loads the remaining count.
   localparam stall_cnt_t c_BR_LOAD_INIT = stall_cnt_t'(BR_LOAD_STALL - 1);
   localparam stall_cnt_t c_BR_ALU_INIT  = stall_cnt_t'(BR_ALU_STALL - 1);
   localparam stall_cnt_t c_LU_INIT      = '0;

   hzState_t   r_state, w_state_nxt;
   stall_cnt_t r_stall_cnt, w_stall_cnt_nxt, w_stall_dec, w_stall_init;
   logic       r_squash, w_squash_nxt;
   logic       w_load_use, w_br_load, w_br_alu, w_hazard, w_dwait;

   hazard_detect u_detect (
      .i_dec_rs      (dec_rs),
      .i_dec_rt      (dec_rt),
      .i_dec_uses_rs (dec_uses_rs),
      .i_dec_uses_rt (dec_uses_rt),
      .i_dec_isbr    (dec_isbr),
      .i_ex_dest     (ex_dest),
      .i_ex_rfWEN    (ex_rfWEN),
      .i_ex_memREN   (ex_memREN),
      .o_load_use    (w_load_use),
      .o_br_load     (w_br_load),
      .o_br_alu      (w_br_alu)
   );

   assign w_hazard     = w_load_use || w_br_load || w_br_alu;
   assign w_dwait      = (mem_dREN || mem_dWEN) && !dhit;
   assign w_stall_dec  = r_stall_cnt - 1'b1;
   assign w_stall_init = w_br_load ? c_BR_LOAD_INIT :
                         w_br_alu  ? c_BR_ALU_INIT  : c_LU_INIT;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= HZ_RUN;
         r_stall_cnt <= '0;
         r_squash    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_squash    <= w_squash_nxt;
      end
   end

   always_comb begin
      pcEN            = 1'b1;
      if_id_EN        = 1'b1;
      id_ex_EN        = 1'b1;
      ex_mem_EN       = 1'b1;
      mem_wb_EN       = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      mem_wb_flush    = 1'b0;
      halt            = 1'b0;
      w_state_nxt     = r_state;
      w_stall_cnt_nxt = r_stall_cnt;
      w_squash_nxt    = r_squash;

      if (r_state == HZ_HALTED) begin
         pcEN      = 1'b0;
         if_id_EN  = 1'b0;
         id_ex_EN  = 1'b0;
         ex_mem_EN = 1'b0;
         mem_wb_EN = 1'b0;
         halt      = 1'b1;
      end else if (w_dwait) begin
         // Freeze everything upstream of MEM; WB receives a bubble.
         pcEN         = 1'b0;
         if_id_EN     = 1'b0;
         id_ex_EN     = 1'b0;
         ex_mem_EN    = 1'b0;
         mem_wb_flush = 1'b1;
         if (dec_redirect && !ihit)
            w_squash_nxt = 1'b1;
      end else if (r_state == HZ_STALL) begin
         pcEN        = 1'b0;
         if_id_EN    = 1'b0;
         id_ex_flush = 1'b1;
         w_stall_cnt_nxt = w_stall_dec;
         if (w_stall_dec == '0)
            w_state_nxt = HZ_RUN;
      end else if (w_hazard) begin
         // Stall wins over a same-cycle redirect; the branch re-resolves
         // once it is released from decode.
         pcEN        = 1'b0;
         if_id_EN    = 1'b0;
         id_ex_flush = 1'b1;
         w_stall_cnt_nxt = w_stall_init;
         if (w_stall_init != '0)
            w_state_nxt = HZ_STALL;
      end else if (dec_redirect) begin
         if (ihit) begin
            if_id_flush  = 1'b1;
            w_squash_nxt = 1'b0;
         end else begin
            // Wrong-path fetch still outstanding: remember to squash it.
            pcEN         = 1'b0;
            if_id_EN     = 1'b0;
            w_squash_nxt = 1'b1;
         end
      end else if (!ihit) begin
         pcEN        = 1'b0;
         if_id_flush = 1'b1;
      end else if (r_squash) begin
         if_id_flush  = 1'b1;
         w_squash_nxt = 1'b0;
      end

      if (wb_halt && (r_state != HZ_HALTED))
         w_state_nxt = HZ_HALTED;

      if (RST) begin
         pcEN         = 1'b1;
         if_id_EN     = 1'b1;
         id_ex_EN     = 1'b1;
         ex_mem_EN    = 1'b1;
         mem_wb_EN    = 1'b1;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         mem_wb_flush = 1'b0;
         halt         = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   word_t r_stall_cycles, r_flush_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!pcEN && (r_state != HZ_HALTED) && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if ((if_id_flush || id_ex_flush || mem_wb_flush) && (r_flush_count != '1))
            r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed self-checking bench for hazard_unit. Expected
//                control vectors are queued when stimulus is applied and
//                popped when the DUT outputs are sampled mid-cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;
   logic        CLK = 1'b0;
   logic        RST;
   logic [4:0]  dec_rs, dec_rt, ex_dest;
   logic        dec_uses_rs, dec_uses_rt, dec_isbr, dec_redirect;
   logic        ex_rfWEN, ex_memREN, mem_dREN, mem_dWEN, dhit, ihit, wb_halt;
   logic        pcEN, if_id_EN, id_ex_EN, ex_mem_EN, mem_wb_EN;
   logic        if_id_flush, id_ex_flush, mem_wb_flush, halt;
   logic [31:0] stall_cycles, flush_count;

   int n_assert = 0;
   int n_fail   = 0;

   logic [8:0] exp_q[$];
   string      tag_q[$];

   // {pcEN,if_id_EN,id_ex_EN,ex_mem_EN,mem_wb_EN,if_id_fl,id_ex_fl,mem_wb_fl,halt}
   localparam logic [8:0] c_RUN    = 9'b11111_000_0;
   localparam logic [8:0] c_DSTALL = 9'b00111_010_0;
   localparam logic [8:0] c_DWAIT  = 9'b00001_001_0;
   localparam logic [8:0] c_HALT   = 9'b00000_000_1;
   localparam logic [8:0] c_IFLUSH = 9'b11111_100_0;
   localparam logic [8:0] c_IWAIT  = 9'b01111_100_0;
   localparam logic [8:0] c_RMISS  = 9'b00111_000_0;

`ifdef HAZARD_PERF_EN
   localparam logic [31:0] c_EXP_STALLS  = 32'd3;
   localparam logic [31:0] c_EXP_FLUSHES = 32'd2;
`else
   localparam logic [31:0] c_EXP_STALLS  = 32'd0;
   localparam logic [31:0] c_EXP_FLUSHES = 32'd0;
`endif

   hazard_unit #(.BR_LOAD_STALL(2), .BR_ALU_STALL(1)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .dec_rs       (dec_rs),
      .dec_rt       (dec_rt),
      .dec_uses_rs  (dec_uses_rs),
      .dec_uses_rt  (dec_uses_rt),
      .dec_isbr     (dec_isbr),
      .dec_redirect (dec_redirect),
      .ex_dest      (ex_dest),
      .ex_rfWEN     (ex_rfWEN),
      .ex_memREN    (ex_memREN),
      .mem_dREN     (mem_dREN),
      .mem_dWEN     (mem_dWEN),
      .dhit         (dhit),
      .ihit         (ihit),
      .wb_halt      (wb_halt),
      .pcEN         (pcEN),
      .if_id_EN     (if_id_EN),
      .id_ex_EN     (id_ex_EN),
      .ex_mem_EN    (ex_mem_EN),
      .mem_wb_EN    (mem_wb_EN),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .mem_wb_flush (mem_wb_flush),
      .halt         (halt),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      RST = 1'b0; dec_rs = '0; dec_rt = '0; ex_dest = '0;
      dec_uses_rs = 1'b0; dec_uses_rt = 1'b0; dec_isbr = 1'b0; dec_redirect = 1'b0;
      ex_rfWEN = 1'b0; ex_memREN = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
      dhit = 1'b1; ihit = 1'b1; wb_halt = 1'b0;
   endtask

   // Producer in EX and consumer (rs) in decode.
   task automatic dep(input logic isbr, input logic load, input logic [4:0] r);
      idle();
      dec_isbr = isbr; dec_rs = r; dec_uses_rs = 1'b1;
      ex_dest = r; ex_rfWEN = 1'b1; ex_memREN = load;
   endtask

   // Called just after a falling edge with inputs applied; samples the Mealy
   // outputs mid-low-phase, then advances to the next falling edge.
   task automatic chk(input string tag, input logic [8:0] e);
      logic [8:0] o, x;
      string      t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #2;
      o = {pcEN, if_id_EN, id_ex_EN, ex_mem_EN, mem_wb_EN,
           if_id_flush, id_ex_flush, mem_wb_flush, halt};
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      n_assert++;
      assert (o === x) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", t, o, x);
      end
      @(negedge CLK);
   endtask

   task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   initial begin
      idle();
      RST = 1'b1;
      @(negedge CLK);
      // Reset overrides a live hazard on the outputs.
      dep(1'b0, 1'b1, 5'd2); RST = 1'b1;   chk("rst_override", c_RUN);
      idle(); RST = 1'b1;                  chk("rst_idle", c_RUN);
      idle();                              chk("run_after_rst", c_RUN);

      // Load-use: one stall cycle, then full flow.
      dep(1'b0, 1'b1, 5'd2);               chk("lu_detect", c_DSTALL);
      idle();                              chk("lu_release", c_RUN);
      // $zero and unused source never stall.
      dep(1'b0, 1'b1, 5'd0);               chk("lu_zero_reg", c_RUN);
      idle(); dec_rt = 5'd5; ex_dest = 5'd5; ex_rfWEN = 1'b1; ex_memREN = 1'b1;
                                           chk("lu_rt_unused", c_RUN);
      dec_uses_rt = 1'b1;                  chk("lu_rt_used", c_DSTALL);

      // Branch on load result: two stall cycles.
      dep(1'b1, 1'b1, 5'd3);               chk("brld_c1", c_DSTALL);
      idle(); dec_isbr = 1'b1;             chk("brld_c2", c_DSTALL);
      idle(); dec_isbr = 1'b1;             chk("brld_done", c_RUN);
      // Branch on ALU result: one stall cycle.
      dep(1'b1, 1'b0, 5'd3);               chk("bralu_c1", c_DSTALL);
      idle(); dec_isbr = 1'b1;             chk("bralu_done", c_RUN);

      // Dmem wait in the middle of a branch-load stall freezes the count.
      dep(1'b1, 1'b1, 5'd3);               chk("dw_stall_start", c_DSTALL);
      for (int i = 0; i < 4; i++) begin
         dep(1'b1, 1'b1, 5'd3); mem_dREN = 1'b1; dhit = 1'b0;
         chk("dw_wait", c_DWAIT);
      end
      idle(); mem_dREN = 1'b1;             chk("dw_resume_stall", c_DSTALL);
      idle();                              chk("dw_resume_run", c_RUN);

      // Redirect with and without an instruction hit.
      idle(); dec_redirect = 1'b1;         chk("redir_hit", c_IFLUSH);
      idle();                              chk("redir_hit_after", c_RUN);
      for (int i = 0; i < 3; i++) begin
         idle(); dec_redirect = 1'b1; ihit = 1'b0;
         chk("redir_miss", c_RMISS);
      end
      idle();                              chk("squash_flush", c_IFLUSH);
      idle();                              chk("squash_cleared", c_RUN);
      idle(); ihit = 1'b0;                 chk("imem_wait", c_IWAIT);
      // Stall beats redirect; redirect honoured once released.
      dep(1'b0, 1'b1, 5'd7); dec_redirect = 1'b1; chk("stall_vs_redir", c_DSTALL);
      idle(); dec_redirect = 1'b1;         chk("redir_after_stall", c_IFLUSH);

      // Performance counters from a clean reset.
      idle(); RST = 1'b1;                  chk("perf_rst", c_RUN);
      idle();                              chk("perf_idle", c_RUN);
      chk32("stall_cycles_rst", stall_cycles, 32'd0);
      chk32("flush_count_rst", flush_count, 32'd0);
      dep(1'b0, 1'b1, 5'd4);               chk("perf_lu", c_DSTALL);
      idle(); dec_redirect = 1'b1; ihit = 1'b0; chk("perf_rmiss1", c_RMISS);
      idle(); dec_redirect = 1'b1; ihit = 1'b0; chk("perf_rmiss2", c_RMISS);
      idle();                              chk("perf_squash", c_IFLUSH);
      idle();                              chk("perf_idle2", c_RUN);
      chk32("stall_cycles", stall_cycles, c_EXP_STALLS);
      chk32("flush_count", flush_count, c_EXP_FLUSHES);

      // Halt is sticky and ignores hazards until reset.
      idle(); wb_halt = 1'b1;              chk("halt_edge", c_RUN);
      for (int i = 0; i < 12; i++) begin
         dep(1'b0, 1'b1, 5'd2); ihit = 1'b0; dec_redirect = 1'b1;
         chk("halted", c_HALT);
      end
      chk32("stall_cycles_halted", stall_cycles, c_EXP_STALLS);
      idle(); RST = 1'b1;                  chk("halt_rst", c_RUN);
      idle();                              chk("halt_cleared", c_RUN);
      dep(1'b0, 1'b1, 5'd2);               chk("post_halt_lu", c_DSTALL);
      idle();                              chk("post_halt_run", c_RUN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
